// File: rtl/pipeline_ctrl.sv
// Hazard / control-flow arbiter for a 5-stage pipeline: resolves branch, trap,
// load-use and jump events by fixed priority and tracks the stall/kernel state.
module pipeline_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic        ID_UsesRt,
  input  logic        EX_MemRd,
  input  logic [4:0]  EX_WrReg,
  input  logic        EX_BranchTaken,
  input  logic        ID_Jump_I,
  input  logic        ID_Jump_R,
  input  logic        ID_EXP,
  input  logic        ID_IRQ,
  input  logic        IRQ,
  input  logic        PCSuper,
  output logic        PC_Write,
  output logic        IFID_Write,
  output logic        IFID_Flush,
  output logic        IDEX_Flush,
  output logic [2:0]  PCSel,
  output logic        IRQ_to_ID,
  output logic [1:0]  ctrl_state,
  output logic [15:0] stall_count
);

  typedef enum logic [2:0] {
    EV_NONE, EV_BR, EV_EXP, EV_IRQ, EV_LUH, EV_JR, EV_JI
  } event_e;

  localparam logic [2:0] SEL_PC4  = 3'b000;
  localparam logic [2:0] SEL_BR   = 3'b001;
  localparam logic [2:0] SEL_JT   = 3'b010;
  localparam logic [2:0] SEL_JR   = 3'b011;
  localparam logic [2:0] SEL_IRQV = 3'b100;
  localparam logic [2:0] SEL_EXCV = 3'b101;

  logic        stall_q, stall_d;
  logic        kmode_q, kmode_d;
  logic [15:0] cnt_q, cnt_d;
  logic        luh;
  event_e      evt;

  // A load into r0 never creates a dependency; the stall cycle itself masks
  // the hazard so one instruction cannot stall twice.
  always_comb begin
    luh = EX_MemRd && (EX_WrReg != 5'd0) && !stall_q &&
          ((EX_WrReg == ID_Rs) || (ID_UsesRt && (EX_WrReg == ID_Rt)));
  end

  always_comb begin
    if (EX_BranchTaken)  evt = EV_BR;
    else if (ID_EXP)     evt = EV_EXP;
    else if (ID_IRQ)     evt = EV_IRQ;
    else if (luh)        evt = EV_LUH;
    else if (ID_Jump_R)  evt = EV_JR;
    else if (ID_Jump_I)  evt = EV_JI;
    else                 evt = EV_NONE;
  end

  always_comb begin
    PC_Write   = 1'b1;
    IFID_Write = 1'b1;
    IFID_Flush = 1'b0;
    IDEX_Flush = 1'b0;
    PCSel      = SEL_PC4;
    case (evt)
      EV_BR:  begin PCSel = SEL_BR;   IFID_Flush = 1'b1; IDEX_Flush = 1'b1; end
      EV_EXP: begin PCSel = SEL_EXCV; IFID_Flush = 1'b1; end
      EV_IRQ: begin PCSel = SEL_IRQV; IFID_Flush = 1'b1; end
      EV_LUH: begin PC_Write = 1'b0; IFID_Write = 1'b0; IDEX_Flush = 1'b1; end
      EV_JR:  begin PCSel = SEL_JR;   IFID_Flush = 1'b1; end
      EV_JI:  begin PCSel = SEL_JT;   IFID_Flush = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    stall_d = (evt == EV_LUH);
    kmode_d = kmode_q;
    if ((evt == EV_EXP) || (evt == EV_IRQ))
      kmode_d = 1'b1;
    else if (kmode_q && !PCSuper && !ID_EXP && !ID_IRQ)
      kmode_d = 1'b0;  // fetching user-space code again: trap handler returned
    cnt_d = cnt_q;
    if ((evt == EV_LUH) && (cnt_q != 16'hFFFF))
      cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= 1'b0;
      kmode_q <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      stall_q <= stall_d;
      kmode_q <= kmode_d;
      cnt_q   <= cnt_d;
    end
  end

  assign IRQ_to_ID   = IRQ && !kmode_q && !PCSuper && !stall_q;
  assign ctrl_state  = {kmode_q, stall_q};
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: a driver pushes model predictions,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  ID_Rs = '0, ID_Rt = '0, EX_WrReg = '0;
  logic        ID_UsesRt = 0, EX_MemRd = 0, EX_BranchTaken = 0, ID_Jump_I = 0;
  logic        ID_Jump_R = 0, ID_EXP = 0, ID_IRQ = 0, IRQ = 0, PCSuper = 0;
  logic        PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, IRQ_to_ID;
  logic [2:0]  PCSel;
  logic [1:0]  ctrl_state;
  logic [15:0] stall_count;

  pipeline_ctrl dut (
    .clk(clk), .reset(reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .EX_MemRd(EX_MemRd), .EX_WrReg(EX_WrReg), .EX_BranchTaken(EX_BranchTaken),
    .ID_Jump_I(ID_Jump_I), .ID_Jump_R(ID_Jump_R), .ID_EXP(ID_EXP), .ID_IRQ(ID_IRQ),
    .IRQ(IRQ), .PCSuper(PCSuper), .PC_Write(PC_Write), .IFID_Write(IFID_Write),
    .IFID_Flush(IFID_Flush), .IDEX_Flush(IDEX_Flush), .PCSel(PCSel),
    .IRQ_to_ID(IRQ_to_ID), .ctrl_state(ctrl_state), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rs, rt;
    logic       uses_rt, memrd;
    logic [4:0] wr;
    logic       br, exc, id_irq, jr, ji, irq, pcsuper;
  } in_t;

  typedef struct packed {
    logic        pc_write, ifid_write, ifid_flush, idex_flush;
    logic [2:0]  pcsel;
    logic        irq_to_id;
    logic [1:0]  cstate;
    logic [15:0] cnt;
  } out_t;

  out_t sb_q[$];
  int   n_cmp = 0, n_bad = 0;

  // Reference state
  bit m_stall = 0, m_kmode = 0;
  int m_cnt = 0;

  task automatic chk(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic apply(input in_t v);
    ID_Rs = v.rs; ID_Rt = v.rt; ID_UsesRt = v.uses_rt; EX_MemRd = v.memrd;
    EX_WrReg = v.wr; EX_BranchTaken = v.br; ID_EXP = v.exc; ID_IRQ = v.id_irq;
    ID_Jump_R = v.jr; ID_Jump_I = v.ji; IRQ = v.irq; PCSuper = v.pcsuper;
  endtask

  // Priority list: index of the first asserted event, 0 when none.
  // 1=branch 2=exception 3=interrupt 4=load-use 5=jr 6=j
  task automatic predict(input in_t v);
    bit   ev[1:6];
    int   win;
    bit   hz;
    out_t e;
    int   sel_of[0:6] = '{0, 1, 5, 4, 0, 3, 2};
    hz = v.memrd && v.wr != 0 && !m_stall &&
         (v.wr == v.rs || (v.uses_rt && v.wr == v.rt));
    ev = '{v.br, v.exc, v.id_irq, hz, v.jr, v.ji};
    win = 0;
    for (int i = 6; i >= 1; i--) if (ev[i]) win = i;
    e.pcsel      = 3'(sel_of[win]);
    e.pc_write   = (win != 4);
    e.ifid_write = (win != 4);
    e.ifid_flush = (win inside {1, 2, 3, 5, 6});
    e.idex_flush = (win inside {1, 4});
    e.irq_to_id  = v.irq && !m_kmode && !v.pcsuper && !m_stall;
    e.cstate     = {m_kmode, m_stall};
    e.cnt        = 16'(m_cnt);
    sb_q.push_back(e);
    // state after the coming edge
    m_stall = (win == 4);
    if (win == 2 || win == 3) m_kmode = 1;
    else if (m_kmode && !v.pcsuper && !v.exc && !v.id_irq) m_kmode = 0;
    if (win == 4 && m_cnt < 65535) m_cnt = m_cnt + 1;
  endtask

  task automatic cycle(input in_t v);
    @(posedge clk); #1;
    apply(v);
    predict(v);
  endtask

  always @(negedge clk) begin
    out_t e, g;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      g = {PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, PCSel, IRQ_to_ID,
           ctrl_state, stall_count};
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL scoreboard t=%0t: got pcw=%b ifw=%b iff=%b idf=%b sel=%0d irq=%b st=%b cnt=%h; expected pcw=%b ifw=%b iff=%b idf=%b sel=%0d irq=%b st=%b cnt=%h",
                 $time, g.pc_write, g.ifid_write, g.ifid_flush, g.idex_flush, g.pcsel,
                 g.irq_to_id, g.cstate, g.cnt, e.pc_write, e.ifid_write, e.ifid_flush,
                 e.idex_flush, e.pcsel, e.irq_to_id, e.cstate, e.cnt);
      end
    end
  end

  function automatic in_t rand_in();
    in_t v;
    v.rs = 5'($urandom_range(0, 3));
    v.rt = 5'($urandom_range(0, 3));
    v.wr = 5'($urandom_range(0, 3));
    v.uses_rt = 1'($urandom);
    v.memrd   = ($urandom_range(0, 1) == 0);
    v.br      = ($urandom_range(0, 7) == 0);
    v.exc     = ($urandom_range(0, 15) == 0);
    v.id_irq  = ($urandom_range(0, 15) == 0);
    v.jr      = ($urandom_range(0, 7) == 0);
    v.ji      = ($urandom_range(0, 7) == 0);
    v.irq     = 1'($urandom);
    v.pcsuper = 1'($urandom);
    return v;
  endfunction

  initial begin
    in_t z, v;
    z = '0;
    // reset state with all inputs low
    #3;
    chk("rst_ctrl_state", int'(ctrl_state), 0);
    chk("rst_stall_count", int'(stall_count), 0);
    chk("rst_pc_write", int'(PC_Write), 1);
    chk("rst_ifid_write", int'(IFID_Write), 1);
    chk("rst_flushes", int'({IFID_Flush, IDEX_Flush}), 0);
    chk("rst_pcsel", int'(PCSel), 0);
    chk("rst_irq_to_id", int'(IRQ_to_ID), 0);
    @(negedge clk); reset = 1'b1;

    // load-use on Rs
    v = z; v.memrd = 1; v.wr = 5; v.rs = 5;
    cycle(v);
    #3 chk("luh_pc_write", int'(PC_Write), 0);
    cycle(v);
    #3 chk("luh_c1_state", int'(ctrl_state), 1);
    chk("luh_c1_pc_write", int'(PC_Write), 1);
    chk("luh_c1_count", int'(stall_count), 1);
    // r0 never hazards
    v = z; v.memrd = 1; v.wr = 0; v.rs = 0;
    cycle(v); cycle(v);
    #3 chk("r0_count", int'(stall_count), 1);
    // branch beats load-use and jump
    v = z; v.memrd = 1; v.wr = 7; v.rs = 7; v.br = 1; v.ji = 1;
    cycle(v);
    #3 chk("br_pcsel", int'(PCSel), 1);
    cycle(z);
    #3 chk("br_no_stall", int'(ctrl_state), 0);
    chk("br_count", int'(stall_count), 1);
    // Rt hazard only when used
    v = z; v.memrd = 1; v.wr = 3; v.rt = 3; v.uses_rt = 0; cycle(v);
    v.uses_rt = 1; cycle(v); cycle(z);
    // interrupt entry and return
    v = z; v.irq = 1; cycle(v);
    v.id_irq = 1; cycle(v);
    v = z; v.irq = 1; v.pcsuper = 1; cycle(v); cycle(v);
    #3 chk("kmode_irq_gated", int'(IRQ_to_ID), 0);
    v.exc = 1; cycle(v);
    v = z; v.pcsuper = 0; cycle(v); cycle(v);
    #3 chk("kmode_cleared", int'(ctrl_state), 0);

    // async reset from ctrl_state=11
    v = z; v.exc = 1; cycle(v);
    v = z; v.pcsuper = 1; v.memrd = 1; v.wr = 9; v.rs = 9; cycle(v);
    v = z; v.pcsuper = 1; cycle(v);
    @(negedge clk); #1;
    chk("pre_reset_state", int'(ctrl_state), 3);
    reset = 1'b0; apply(z); #1;
    chk("async_rst_state", int'(ctrl_state), 0);
    chk("async_rst_count", int'(stall_count), 0);
    m_stall = 0; m_kmode = 0; m_cnt = 0;
    #1 reset = 1'b1;
    cycle(z); cycle(z);

    for (int i = 0; i < 3000; i++) cycle(rand_in());

    // saturation: preload the counter near the top
    cycle(z);
    @(negedge clk); #1;
    force dut.cnt_q = 16'hFFFE;
    #1 release dut.cnt_q;
    m_cnt = 16'hFFFE;
    v = z; v.memrd = 1; v.wr = 4; v.rs = 4;
    cycle(v); cycle(z); cycle(v); cycle(z); cycle(v); cycle(z);
    #3 chk("sat_count", int'(stall_count), 16'hFFFF);

    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have the following ports, in this order (name, direction, width, meaning):
  clk  in  1  single clock; all state changes on rising edge.
  reset  in  1  asynchronous, active-low reset (0 = reset asserted).
  ID_Rs  in  5  Rs field of the instruction in ID.
  ID_Rt  in  5  Rt field of the instruction in ID.
  ID_UsesRt  in  1  ID instruction reads Rt.
  EX_MemRd  in  1  instruction in EX is a load.
  EX_WrReg  in  5  destination register of the instruction in EX.
  EX_BranchTaken  in  1  branch in EX resolved taken.
  ID_Jump_I  in  1  ID holds j/jal.
  ID_Jump_R  in  1  ID holds jr/jalr.
  ID_EXP  in  1  ID holds an undefined instruction.
  ID_IRQ  in  1  ID has been converted to an interrupt trap.
  IRQ  in  1  raw external interrupt request.
  PCSuper  in  1  PC[31] of the instruction in ID.
  PC_Write  out  1  PC register load enable.
  IFID_Write  out  1  IF/ID register load enable.
  IFID_Flush  out  1  zero IF/ID contents on the next edge.
  IDEX_Flush  out  1  zero ID/EX control bits on the next edge (bubble).
  PCSel  out  3  next-PC source, encoded as listed in REQ-004.
  IRQ_to_ID  out  1  gated interrupt request to the decoder.
  ctrl_state  out  2  {kmode, stall}.
  stall_count  out  16  saturating count of load-use stalls.

Function
REQ-002 SHALL hold two state bits, updated on the rising edge of clk:
  - stall: 1 for exactly one cycle after a load-use hazard is detected.
  - kmode: 1 while in the kernel trap handler.
REQ-003 SHALL detect a load-use hazard (luh) when all of the following hold:
  - EX_MemRd = 1, EX_WrReg != 0, and stall = 0;
  - EX_WrReg == ID_Rs, or (ID_UsesRt = 1 and EX_WrReg == ID_Rt).
REQ-004 SHALL encode PCSel as follows:
  000 = PC+4; 001 = branch target; 010 = JT; 011 = jr target; 100 = interrupt vector 0x80000004; 101 = exception vector 0x80000008; 110 and 111 are never driven.
REQ-005 SHALL resolve events combinationally each cycle in fixed priority order (first match wins):
  1. EX_BranchTaken
  2. ID_EXP
  3. ID_IRQ
  4. luh
  5. ID_Jump_R
  6. ID_Jump_I
  7. none
REQ-006 EX_BranchTaken SHALL drive PCSel=001, IFID_Flush=1 and IDEX_Flush=1; every other event in the same cycle SHALL be ignored.
REQ-007 ID_EXP SHALL drive PCSel=101 and IFID_Flush=1, and SHALL set kmode on the next edge.
REQ-008 ID_IRQ SHALL drive PCSel=100 and IFID_Flush=1, and SHALL set kmode on the next edge.
REQ-009 luh SHALL drive PC_Write=0, IFID_Write=0, IDEX_Flush=1 and PCSel=000, and SHALL set stall on the next edge.
REQ-010 ID_Jump_R SHALL drive PCSel=011 and IFID_Flush=1; ID_Jump_I SHALL drive PCSel=010 and IFID_Flush=1.
REQ-011 When no event is active: PC_Write=1, IFID_Write=1, IFID_Flush=0, IDEX_Flush=0, PCSel=000.
REQ-012 stall SHALL clear on the edge following the cycle in which it was 1; consecutive load-use stalls on one instruction are impossible.
REQ-013 IRQ_to_ID SHALL equal IRQ AND NOT kmode AND NOT PCSuper AND NOT stall.
REQ-014 kmode SHALL clear on an edge where kmode=1, PCSuper=0, and neither ID_EXP nor ID_IRQ is active (return to user space).
REQ-015 If kmode=1 and ID_EXP is active, the block SHALL vector (PCSel=101) and kmode SHALL remain 1.
REQ-016 stall_count SHALL increment by 1 on every edge where luh is the winning event, and SHALL saturate at 0xFFFF.
REQ-017 An event that loses priority SHALL have no state effect: no stall set and no stall_count increment.
REQ-018 ctrl_state SHALL equal {kmode, stall}.

Reset
REQ-019 While reset=0, asynchronously: stall=0, kmode=0, stall_count=0, ctrl_state=00.
REQ-020 With reset=0 and all inputs 0, outputs SHALL be: PC_Write=1, IFID_Write=1, IFID_Flush=0, IDEX_Flush=0, PCSel=000, IRQ_to_ID=0.
REQ-021 Reset asserted mid-stall or mid-kernel SHALL abandon that state immediately, with no pending effect after release.
REQ-022 The first edge after reset rises SHALL use normal priority evaluation.

Verification
REQ-023 Load-use: EX_MemRd=1, EX_WrReg=5, ID_Rs=5 -> cycle 0: PC_Write=0, IFID_Write=0, IDEX_Flush=1; cycle 1: ctrl_state=01, outputs normal; stall_count=1.
REQ-024 Zero register: EX_MemRd=1, EX_WrReg=0, ID_Rs=0 -> no stall; PC_Write=1; stall_count unchanged.
REQ-025 Priority: EX_BranchTaken=1 together with luh and ID_Jump_I -> PCSel=001, both flushes 1, stall stays 0, stall_count unchanged.
REQ-026 Interrupt: IRQ=1, PCSuper=0 -> IRQ_to_ID=1; then ID_IRQ=1 -> PCSel=100, kmode=1 next edge; IRQ_to_ID=0 while PCSuper=1; PCSuper=0 -> kmode clears.
REQ-027 Saturation: 65537 load-use events -> stall_count=0xFFFF.
REQ-028 Async reset: reset pulsed low between edges while ctrl_state=11 -> ctrl_state=00 immediately, stall_count=0.
